// File: rtl/uart_top.sv
// 8N1 UART with independent transmitter and receiver running on one clock.
// Ports: in_data/in_valid/out_BUSY/out_signal (TX), in_signal/out_valid/out_word (RX).
module uart_top #(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_BUSY,
    output logic       out_signal,
    input  logic       in_signal,
    output logic       out_valid,
    output logic [7:0] out_word
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

    // ---------------- transmitter ----------------
    st_t           tx_st_q, tx_st_d;
    logic [CW-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_line_q, tx_line_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q   <= IDLE;
            tx_baud_q <= '0;
            tx_bit_q  <= '0;
            tx_sh_q   <= '0;
            tx_line_q <= 1'b1;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_baud_q <= tx_baud_d;
            tx_bit_q  <= tx_bit_d;
            tx_sh_q   <= tx_sh_d;
            tx_line_q <= tx_line_d;
        end
    end

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_baud_d = tx_baud_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_line_d = tx_line_q;
        unique case (tx_st_q)
            IDLE: begin
                tx_line_d = 1'b1;
                tx_baud_d = '0;
                if (in_valid) begin
                    tx_st_d   = START;
                    tx_sh_d   = in_data;
                    tx_line_d = 1'b0;
                end
            end
            START: begin
                if (tx_baud_q == LAST) begin
                    tx_st_d   = DATA;
                    tx_baud_d = '0;
                    tx_bit_d  = '0;
                    tx_line_d = tx_sh_q[0];
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            DATA: begin
                if (tx_baud_q == LAST) begin
                    tx_baud_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_st_d   = STOP;
                        tx_line_d = 1'b1;
                    end else begin
                        // Line takes the next bit while the register shifts it down.
                        tx_bit_d  = tx_bit_q + 1'b1;
                        tx_line_d = tx_sh_q[1];
                        tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            STOP: begin
                if (tx_baud_q == LAST) begin
                    tx_st_d   = IDLE;
                    tx_baud_d = '0;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: tx_st_d = IDLE;
        endcase
    end

    assign out_BUSY   = (tx_st_q != IDLE);
    assign out_signal = tx_line_q;

    // ---------------- receiver ----------------
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic          rx_s;
    st_t           rx_st_q, rx_st_d;
    logic [CW-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          ferr_q, ferr_d;
    logic          valid_q, valid_d;
    logic [7:0]    word_q, word_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            rx_st_q   <= IDLE;
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
            word_q    <= '0;
        end else begin
            sync_q    <= {sync_q[0], in_signal};
            rx_prev_q <= rx_s;
            rx_st_q   <= rx_st_d;
            rx_baud_q <= rx_baud_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
            word_q    <= word_d;
        end
    end

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_baud_d = rx_baud_q;
        rx_bit_d  = rx_bit_q;
        rx_sh_d   = rx_sh_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        word_d    = word_q;
        unique case (rx_st_q)
            IDLE: begin
                rx_baud_d = '0;
                if (rx_prev_q && !rx_s) rx_st_d = START;
            end
            START: begin
                if (rx_baud_q == HALF) begin
                    rx_baud_d = '0;
                    rx_bit_d  = '0;
                    rx_st_d   = rx_s ? IDLE : DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_baud_q == LAST) begin
                    rx_baud_d = '0;
                    rx_sh_d   = {rx_s, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_st_d = STOP;
                    else rx_bit_d = rx_bit_q + 1'b1;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            STOP: begin
                // After a framing error, park here until the line idles high.
                if (ferr_q) begin
                    if (rx_s) begin
                        ferr_d  = 1'b0;
                        rx_st_d = IDLE;
                    end
                end else if (rx_baud_q == LAST) begin
                    rx_baud_d = '0;
                    if (rx_s) begin
                        word_d  = rx_sh_q;
                        valid_d = 1'b1;
                        rx_st_d = IDLE;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: rx_st_d = IDLE;
        endcase
    end

    assign out_valid = valid_q;
    assign out_word  = word_q;

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: frame-level TX model, RX scoreboard,
// vector table for direct RX frames and hand sequences for corner cases.
module tb_uart_top;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_BUSY;
    logic       out_signal;
    logic       in_signal;
    logic       out_valid;
    logic [7:0] out_word;
    logic       loop = 1'b0;
    logic       rx_drv = 1'b1;

    int checks = 0;
    int errors = 0;

    assign in_signal = loop ? out_signal : rx_drv;

    always #5 clk = ~clk;

    uart_top #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_BUSY  (out_BUSY),
        .out_signal(out_signal),
        .in_signal (in_signal),
        .out_valid (out_valid),
        .out_word  (out_word)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level TX model: position within a 10-bit frame.
    bit         m_busy = 0;
    int         m_pos = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] rxq[$];
    int         vcnt = 0;

    function automatic logic exp_line();
        int k;
        if (!m_busy) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            m_pos  = 0;
            rxq.delete();
        end else if (m_busy) begin
            m_pos++;
            if (m_pos == 10 * CPB) m_busy = 0;
        end else if (in_valid) begin
            m_busy = 1;
            m_pos  = 0;
            m_byte = in_data;
            if (loop) rxq.push_back(in_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("tx_line", out_signal, exp_line());
            chk("tx_busy", out_BUSY, m_busy);
            if (out_valid) begin
                vcnt++;
                if (rxq.size() == 0) chk("rx_unexpected_valid", out_valid, 0);
                else chk("rx_word", out_word, rxq.pop_front());
            end
        end
    end

    task automatic wait_tx_done();
        int n;
        n = 0;
        while ((out_BUSY || m_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_done_timeout", n < 4000, 1);
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        if (stop) rxq.push_back(d);
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (CPB) @(negedge clk);
        end
        if (!stop) repeat (2 * CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_word;
        int         exp_valid;
    } rx_vec_t;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rx_vec_t vt[6];
        bit      a5_seq[10];
        int      busy_cnt, gap, n, v0, hold;

        vt[0] = '{8'h7E, 1'b0, 8'h55, 0};
        vt[1] = '{8'h81, 1'b1, 8'h81, 1};
        vt[2] = '{8'h00, 1'b1, 8'h00, 1};
        vt[3] = '{8'hFF, 1'b0, 8'h00, 0};
        vt[4] = '{8'hA5, 1'b1, 8'hA5, 1};
        vt[5] = '{8'h3C, 1'b0, 8'hA5, 0};
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_line", out_signal, 1);
        chk("rst_busy", out_BUSY, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_word", out_word, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0xA5 bit pattern and busy length; in_data changes mid-frame
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        busy_cnt = 0;
        for (int j = 0; j < 10 * CPB; j++) begin
            if (out_BUSY) busy_cnt++;
            if (j % CPB == CPB / 2) chk("a5_bit", out_signal, a5_seq[j / CPB]);
            @(negedge clk);
        end
        chk("a5_busy_fall", out_BUSY, 0);
        chk("a5_busy_cycles", busy_cnt, 10 * CPB);
        repeat (4) @(negedge clk);

        // Loopback back-to-back 0x3C, 0xFF
        loop = 1'b1;
        v0 = vcnt;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'hFF;
        n = 0;
        gap = 0;
        while (out_BUSY && n < 400) begin
            @(negedge clk);
            n++;
        end
        while (!out_BUSY && n < 400) begin
            gap++;
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        chk("b2b_gap", gap, 1);
        wait_tx_done();
        repeat (2 * CPB) @(negedge clk);
        chk("b2b_valid_cnt", vcnt - v0, 2);
        chk("b2b_word", out_word, 8'hFF);

        // 0x11 requested mid-frame of 0x55 is dropped
        v0 = vcnt;
        in_data  = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        in_data  = 8'h11;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_tx_done();
        repeat (2 * CPB) @(negedge clk);
        chk("drop_valid_cnt", vcnt - v0, 1);
        chk("drop_word", out_word, 8'h55);
        loop = 1'b0;
        repeat (CPB) @(negedge clk);

        // Direct RX frames, including framing errors
        for (int i = 0; i < 6; i++) begin
            v0 = vcnt;
            send_rx(vt[i].data, vt[i].stop);
            chk("vec_valid_cnt", vcnt - v0, vt[i].exp_valid);
            chk("vec_word", out_word, vt[i].exp_word);
        end

        // 3-cycle glitch on the line
        v0 = vcnt;
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_valid_cnt", vcnt - v0, 0);
        chk("glitch_word", out_word, 8'hA5);
        send_rx(8'h5A, 1'b1);
        chk("post_glitch_word", out_word, 8'h5A);

        // Reset in the middle of an RX frame
        v0 = vcnt;
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        rx_drv = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        rst_n  = 1'b0;
        rx_drv = 1'b1;
        @(negedge clk);
        chk("midrst_line", out_signal, 1);
        chk("midrst_busy", out_BUSY, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_word", out_word, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("midrst_no_valid", vcnt - v0, 0);
        chk("midrst_word_after", out_word, 8'h00);

        // TX request on the first edge after reset release
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        in_data  = 8'h96;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_edge_accept", out_BUSY, 1);
        wait_tx_done();
        repeat (4) @(negedge clk);

        // Random loopback traffic with in_valid/in_data noise
        loop = 1'b1;
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            hold = $urandom_range(1, 200);
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        wait_tx_done();
        repeat (3 * CPB) @(negedge clk);
        chk("rand_queue_drained", rxq.size(), 0);
        loop = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
